// File: rtl/dr32e_branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: tracked-branch record,
// redirect FSM encoding and the fall-through PC helper.
package dr32e_pkg;

   typedef struct packed {
      logic [31:0] fallthrough;
      logic        taken;
      logic [31:0] target;
   } bp_entry_t;

   typedef enum logic [1:0] {
      RDR_RUN       = 2'd0,
      RDR_PRED_REQ  = 2'd1,
      RDR_FLUSH_REQ = 2'd2
   } redir_state_e;

   function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc, input logic compr);
      return pc + (compr ? 32'd2 : 32'd4);
   endfunction

endpackage

// File: rtl/dr32e_branch_redirect_ctrl_if.sv
// Fetch, redirect handshake, resolve and statistics signals of the redirect
// controller; slave is the controller side, master the surrounding pipeline.
interface dr32e_branch_redirect_ctrl_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic             fetch_accept_i;
   logic             fetch_is_branch_i;
   logic             fetch_is_compr_i;
   logic [31:0]      fetch_pc_i;
   logic             predict_taken_i;
   logic [31:0]      predict_pc_i;
   logic             fetch_stall_o;
   logic             redirect_req_o;
   logic [31:0]      redirect_pc_o;
   logic             redirect_ack_i;
   logic             flush_o;
   logic             resolve_valid_i;
   logic             resolve_taken_i;
   logic [31:0]      resolve_target_i;
   logic [OCC_W-1:0] occupancy_o;
   logic [CNT_W-1:0] pred_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;
   logic             resolve_err_o;

   modport slave (
      input  fetch_accept_i, fetch_is_branch_i, fetch_is_compr_i, fetch_pc_i,
      input  predict_taken_i, predict_pc_i, redirect_ack_i,
      input  resolve_valid_i, resolve_taken_i, resolve_target_i,
      output fetch_stall_o, redirect_req_o, redirect_pc_o, flush_o,
      output occupancy_o, pred_cnt_o, mispred_cnt_o, resolve_err_o
   );

   modport master (
      output fetch_accept_i, fetch_is_branch_i, fetch_is_compr_i, fetch_pc_i,
      output predict_taken_i, predict_pc_i, redirect_ack_i,
      output resolve_valid_i, resolve_taken_i, resolve_target_i,
      input  fetch_stall_o, redirect_req_o, redirect_pc_o, flush_o,
      input  occupancy_o, pred_cnt_o, mispred_cnt_o, resolve_err_o
   );
endinterface

// File: rtl/dr32e_branch_redirect_ctrl_track_fifo.sv
// In-order FIFO of in-flight branches; head is visible combinationally so the
// resolve stage can compare against it in the same cycle it pops.
module dr32e_bp_track_fifo
   import dr32e_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  bp_entry_t              push_data_i,
   input  logic                   pop_i,
   input  logic                   clear_i,
   output bp_entry_t              head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] occupancy_o
);
   localparam int PTR_W = $clog2(DEPTH);

   bp_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign occupancy_o = count_q;
   assign head_o      = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/dr32e_branch_redirect_ctrl.sv
// Branch redirect controller: issues predicted-taken redirects, tracks branches
// until execute resolves them, and flushes/redirects fetch on a mispredict.
module dr32e_branch_redirect_ctrl
   import dr32e_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   dr32e_branch_redirect_ctrl_if.slave  bus
);
   localparam logic [1:0] ST_RUN       = RDR_RUN;
   localparam logic [1:0] ST_PRED_REQ  = RDR_PRED_REQ;
   localparam logic [1:0] ST_FLUSH_REQ = RDR_FLUSH_REQ;

   logic [1:0]       state_q, state_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic             flush_q, flush_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   bp_entry_t             head, push_entry;
   logic                  fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_occ;
   logic                  stall, push_ok, resolve_hit, mispredict;
   logic [31:0]           correct_pc;

   assign stall       = fifo_full | (state_q != ST_RUN);
   assign push_ok     = bus.fetch_accept_i & bus.fetch_is_branch_i & ~stall;
   assign resolve_hit = bus.resolve_valid_i & ~fifo_empty;
   assign mispredict  = resolve_hit &
                        ((bus.resolve_taken_i != head.taken) |
                         (bus.resolve_taken_i & (bus.resolve_target_i != head.target)));
   assign correct_pc  = bus.resolve_taken_i ? bus.resolve_target_i : head.fallthrough;

   assign push_entry.fallthrough = fallthrough_pc(bus.fetch_pc_i, bus.fetch_is_compr_i);
   assign push_entry.taken       = bus.predict_taken_i;
   assign push_entry.target      = bus.predict_pc_i;

   // A mispredict kills the whole FIFO, including any same-cycle (younger) push.
   dr32e_bp_track_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_ok & ~mispredict),
      .push_data_i (push_entry),
      .pop_i       (resolve_hit),
      .clear_i     (mispredict),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .occupancy_o (fifo_occ)
   );

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      if (mispredict) begin
         state_d       = ST_FLUSH_REQ;
         redirect_pc_d = correct_pc;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (push_ok && bus.predict_taken_i) begin
                  state_d       = ST_PRED_REQ;
                  redirect_pc_d = bus.predict_pc_i;
               end
            end
            ST_PRED_REQ, ST_FLUSH_REQ: begin
               if (bus.redirect_ack_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      flush_d       = mispredict;
      err_d         = err_q | (bus.resolve_valid_i & fifo_empty);
      pred_cnt_d    = pred_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve_hit && (pred_cnt_q != '1))    pred_cnt_d    = pred_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1))  mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_RUN;
         redirect_pc_q <= '0;
         flush_q       <= 1'b0;
         err_q         <= 1'b0;
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         err_q         <= err_d;
         pred_cnt_q    <= pred_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus.fetch_stall_o  = stall;
   assign bus.redirect_req_o = (state_q != ST_RUN);
   assign bus.redirect_pc_o  = redirect_pc_q;
   assign bus.flush_o        = flush_q;
   assign bus.occupancy_o    = fifo_occ;
   assign bus.pred_cnt_o     = pred_cnt_q;
   assign bus.mispred_cnt_o  = mispred_cnt_q;
   assign bus.resolve_err_o  = err_q;

endmodule

// File: tb/tb_dr32e_branch_redirect_ctrl.sv
// Table-driven bench with a scoreboard queue for the branch redirect controller.
module tb_dr32e_branch_redirect_ctrl;
   import dr32e_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   typedef struct {
      logic        acc, br, cmp;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ppc;
      logic        ack, rv, rt;
      logic [31:0] rtgt;
   } stim_t;

   typedef struct {
      logic        stall, req, flush, err;
      logic [31:0] rpc, occ, pcnt, mcnt;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   dr32e_branch_redirect_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   dr32e_branch_redirect_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic stim_t S(input logic acc, input logic br, input logic cmp,
                               input logic [31:0] pc, input logic pt, input logic [31:0] ppc,
                               input logic ack, input logic rv, input logic rt,
                               input logic [31:0] rtgt);
      stim_t s;
      s.acc = acc; s.br = br; s.cmp = cmp; s.pc = pc; s.pt = pt; s.ppc = ppc;
      s.ack = ack; s.rv = rv; s.rt = rt; s.rtgt = rtgt;
      return s;
   endfunction

   function automatic exp_t E(input logic stall, input logic req, input logic [31:0] rpc,
                              input logic flush, input int occ, input int pcnt,
                              input int mcnt, input logic err);
      exp_t e;
      e.stall = stall; e.req = req; e.rpc = rpc; e.flush = flush;
      e.occ = occ; e.pcnt = pcnt; e.mcnt = mcnt; e.err = err;
      return e;
   endfunction

   function automatic stim_t IDLE();
      return S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic stim_t ACK();
      return S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
   endfunction

   function automatic stim_t PUSH(input logic [31:0] pc, input logic cmp,
                                  input logic pt, input logic [31:0] ppc);
      return S(1, 1, cmp, pc, pt, ppc, 0, 0, 0, 0);
   endfunction

   function automatic stim_t RES(input logic rt, input logic [31:0] tgt);
      return S(0, 0, 0, 0, 0, 0, 0, 1, rt, tgt);
   endfunction

   task automatic add(input stim_t s, input exp_t e);
      vec_t v;
      v.s = s;
      v.e = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input stim_t s);
      bus.fetch_accept_i    = s.acc;
      bus.fetch_is_branch_i = s.br;
      bus.fetch_is_compr_i  = s.cmp;
      bus.fetch_pc_i        = s.pc;
      bus.predict_taken_i   = s.pt;
      bus.predict_pc_i      = s.ppc;
      bus.redirect_ack_i    = s.ack;
      bus.resolve_valid_i   = s.rv;
      bus.resolve_taken_i   = s.rt;
      bus.resolve_target_i  = s.rtgt;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cmp_exp(input exp_t e, input string tag);
      chk({tag, ".stall"}, 32'(bus.fetch_stall_o),  32'(e.stall));
      chk({tag, ".req"},   32'(bus.redirect_req_o), 32'(e.req));
      chk({tag, ".rpc"},   bus.redirect_pc_o,       e.rpc);
      chk({tag, ".flush"}, 32'(bus.flush_o),        32'(e.flush));
      chk({tag, ".occ"},   32'(bus.occupancy_o),    e.occ);
      chk({tag, ".pcnt"},  32'(bus.pred_cnt_o),     e.pcnt);
      chk({tag, ".mcnt"},  32'(bus.mispred_cnt_o),  e.mcnt);
      chk({tag, ".err"},   32'(bus.resolve_err_o),  32'(e.err));
      $display("%s: stall=%0b req=%0b rpc=%08h flush=%0b occ=%0d pcnt=%0d mcnt=%0d err=%0b",
               tag, bus.fetch_stall_o, bus.redirect_req_o, bus.redirect_pc_o, bus.flush_o,
               bus.occupancy_o, bus.pred_cnt_o, bus.mispred_cnt_o, bus.resolve_err_o);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input stim_t s, input exp_t e, input string tag);
      exp_t got;
      drive(s);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      cmp_exp(got, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc_m, mc_m;
      logic [31:0] rpc_m;

      drive(IDLE());
      @(posedge clk);
      #1;
      cmp_exp(E(0, 0, 32'h0, 0, 0, 0, 0, 0), "reset");
      rst = 1'b0;

      // stall, req, rpc, flush, occ, pcnt, mcnt, err
      add(PUSH(32'h100, 0, 1, 32'h80),          E(1, 1, 32'h80,  0, 1, 0, 0, 0));
      add(IDLE(),                                E(1, 1, 32'h80,  0, 1, 0, 0, 0));
      add(ACK(),                                 E(0, 0, 32'h80,  0, 1, 0, 0, 0));
      add(RES(1, 32'h80),                        E(0, 0, 32'h80,  0, 0, 1, 0, 0));
      add(S(1, 0, 0, 32'h180, 1, 32'h90, 0, 0, 0, 0), E(0, 0, 32'h80, 0, 0, 1, 0, 0));
      add(PUSH(32'h200, 0, 0, 32'h240),          E(0, 0, 32'h80,  0, 1, 1, 0, 0));
      add(RES(1, 32'h240),                       E(1, 1, 32'h240, 1, 0, 2, 1, 0));
      add(IDLE(),                                E(1, 1, 32'h240, 0, 0, 2, 1, 0));
      add(ACK(),                                 E(0, 0, 32'h240, 0, 0, 2, 1, 0));
      add(PUSH(32'h3FE, 1, 1, 32'h3F0),          E(1, 1, 32'h3F0, 0, 1, 2, 1, 0));
      add(ACK(),                                 E(0, 0, 32'h3F0, 0, 1, 2, 1, 0));
      add(RES(0, 32'h0),                         E(1, 1, 32'h400, 1, 0, 3, 2, 0));
      add(ACK(),                                 E(0, 0, 32'h400, 0, 0, 3, 2, 0));
      add(PUSH(32'h500, 0, 0, 32'h600),          E(0, 0, 32'h400, 0, 1, 3, 2, 0));
      add(PUSH(32'h504, 0, 0, 32'h600),          E(0, 0, 32'h400, 0, 2, 3, 2, 0));
      add(PUSH(32'h508, 0, 0, 32'h600),          E(0, 0, 32'h400, 0, 3, 3, 2, 0));
      add(PUSH(32'h50C, 0, 0, 32'h600),          E(1, 0, 32'h400, 0, 4, 3, 2, 0));
      add(PUSH(32'h510, 0, 0, 32'h600),          E(1, 0, 32'h400, 0, 4, 3, 2, 0));
      add(RES(0, 32'h0),                         E(0, 0, 32'h400, 0, 3, 4, 2, 0));
      add(S(1, 1, 0, 32'h510, 0, 32'h600, 0, 1, 0, 0), E(0, 0, 32'h400, 0, 3, 5, 2, 0));
      add(RES(0, 32'h0),                         E(0, 0, 32'h400, 0, 2, 6, 2, 0));
      add(RES(0, 32'h0),                         E(0, 0, 32'h400, 0, 1, 7, 2, 0));
      add(RES(0, 32'h0),                         E(0, 0, 32'h400, 0, 0, 8, 2, 0));
      add(PUSH(32'h100, 0, 1, 32'h80),           E(1, 1, 32'h80,  0, 1, 8, 2, 0));
      add(S(0, 0, 0, 0, 0, 0, 1, 1, 0, 0),       E(1, 1, 32'h104, 1, 0, 9, 3, 0));
      add(IDLE(),                                E(1, 1, 32'h104, 0, 0, 9, 3, 0));
      add(ACK(),                                 E(0, 0, 32'h104, 0, 0, 9, 3, 0));
      add(PUSH(32'h700, 0, 0, 32'h0),            E(0, 0, 32'h104, 0, 1, 9, 3, 0));
      add(S(1, 1, 0, 32'h704, 0, 32'h0, 0, 1, 1, 32'h900), E(1, 1, 32'h900, 1, 0, 10, 4, 0));
      add(ACK(),                                 E(0, 0, 32'h900, 0, 0, 10, 4, 0));
      add(PUSH(32'h800, 0, 1, 32'h880),          E(1, 1, 32'h880, 0, 1, 10, 4, 0));
      add(ACK(),                                 E(0, 0, 32'h880, 0, 1, 10, 4, 0));
      add(RES(1, 32'h890),                       E(1, 1, 32'h890, 1, 0, 11, 5, 0));
      add(ACK(),                                 E(0, 0, 32'h890, 0, 0, 11, 5, 0));
      add(RES(1, 32'h0),                         E(0, 0, 32'h890, 0, 0, 11, 5, 1));
      add(IDLE(),                                E(0, 0, 32'h890, 0, 0, 11, 5, 1));

      foreach (vecs[i]) step(vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));

      // Repeated mispredicts drive both counters into saturation.
      pc_m  = 11;
      mc_m  = 5;
      rpc_m = 32'h890;
      for (int k = 0; k < 12; k++) begin
         step(PUSH(32'h20, 0, 0, 32'h0), E(0, 0, rpc_m, 0, 1, pc_m, mc_m, 1), $sformatf("sat%0d.push", k));
         pc_m  = (pc_m == 15) ? 15 : pc_m + 1;
         mc_m  = (mc_m == 15) ? 15 : mc_m + 1;
         rpc_m = 32'h40;
         step(RES(1, 32'h40), E(1, 1, rpc_m, 1, 0, pc_m, mc_m, 1), $sformatf("sat%0d.res", k));
         step(ACK(), E(0, 0, rpc_m, 0, 0, pc_m, mc_m, 1), $sformatf("sat%0d.ack", k));
      end

      // Reset in the middle of a predicted redirect handshake.
      step(PUSH(32'h100, 0, 1, 32'h80), E(1, 1, 32'h80, 0, 1, 15, 15, 1), "rst.pre");
      drive(IDLE());
      #3;
      rst = 1'b1;
      #1;
      cmp_exp(E(0, 0, 32'h0, 0, 0, 0, 0, 0), "rst.async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(PUSH(32'h900, 0, 0, 32'h0), E(0, 0, 32'h0, 0, 1, 0, 0, 0), "rst.post");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
